cache_set_ram: RTL and testbench

CACHE_SET_RAM -- requirements
Module: cache_set_ram

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_way_bank.sv | 58 +++++
 rtl/cache_set_ram.sv | 114 +++++++++++
 tb/tb_cache_set_ram.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache set RAM: FSM state encoding, default
// geometry and helpers that derive the index and segment-count widths.
`timescale 1ns/1ps
package cache_pkg;

  typedef enum logic [0:0] {StClear, StReady} cache_state_e;

  localparam int unsigned DefWays  = 2;
  localparam int unsigned DefDepth = 64;
  localparam int unsigned DefWidth = 128;
  localparam int unsigned DefSegW  = 32;
  localparam int unsigned DefFwd   = 1;

  function automatic int unsigned calc_iw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned calc_segs(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One way of the cache set RAM: DEPTH x WIDTH storage with a registered read
// port and a segment-masked write port.
//   clk, rst          clock; async active-low reset (read register only)
//   wr_en, w_index    write strobe and set
//   w_mask, w_data    segment enables and write data
//   rd_en, r_index    read strobe and set
//   rd_data           registered read data, held when no read
`timescale 1ns/1ps
module cache_way_bank
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG_W = DefSegW,
  parameter int unsigned FWD   = DefFwd
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [calc_iw(DEPTH)-1:0]              w_index,
  input  logic [calc_segs(WIDTH, SEG_W)-1:0]     w_mask,
  input  logic [WIDTH-1:0]                       w_data,
  input  logic                                   rd_en,
  input  logic [calc_iw(DEPTH)-1:0]              r_index,
  output logic [WIDTH-1:0]                       rd_data
);

  localparam int unsigned Segs = calc_segs(WIDTH, SEG_W);

  // No reset on the array so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q, rd_d, merged;

  // Same-set write bypass: stored line with the freshly written segments overlaid.
  always_comb begin
    merged = mem[r_index];
    if (FWD != 0 && wr_en && (w_index == r_index)) begin
      for (int s = 0; s < Segs; s++) begin
        if (w_mask[s]) merged[s*SEG_W +: SEG_W] = w_data[s*SEG_W +: SEG_W];
      end
    end
    rd_d = rd_en ? merged : rd_q;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < Segs; s++) begin
      if (wr_en && w_mask[s]) mem[w_index][s*SEG_W +: SEG_W] <= w_data[s*SEG_W +: SEG_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/cache_set_ram.sv
// Multi-way cache set RAM with a sequential clear after reset or on flush.
//   clk, rst            clock; async active-low reset
//   ready               high once the array has been cleared
//   flush_req           request a full clear (honoured in READY only)
//   rd_en, r_index      read all ways of a set; result one cycle later
//   rd_data, rd_valid   way k in rd_data[k*WIDTH +: WIDTH]; rd_valid pulses per read
//   wr_en, w_way        write strobe and way mask
//   w_index, w_mask     write set and segment enables
//   data_in             write data, shared by every selected way
`timescale 1ns/1ps
module cache_set_ram
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = DefWays,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG_W = DefSegW,
  parameter int unsigned FWD   = DefFwd
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   ready,
  input  logic                                   flush_req,
  input  logic                                   rd_en,
  input  logic [calc_iw(DEPTH)-1:0]              r_index,
  output logic [WAYS*WIDTH-1:0]                  rd_data,
  output logic                                   rd_valid,
  input  logic                                   wr_en,
  input  logic [WAYS-1:0]                        w_way,
  input  logic [calc_iw(DEPTH)-1:0]              w_index,
  input  logic [calc_segs(WIDTH, SEG_W)-1:0]     w_mask,
  input  logic [WIDTH-1:0]                       data_in
);

  localparam int unsigned Iw   = calc_iw(DEPTH);
  localparam int unsigned Segs = calc_segs(WIDTH, SEG_W);

  cache_state_e      state_q, state_d;
  logic [Iw-1:0]     clr_idx_q, clr_idx_d;
  logic              rd_valid_q;
  logic              rd_go;
  logic [WAYS-1:0]   bank_we;
  logic [Iw-1:0]     bank_idx;
  logic [Segs-1:0]   bank_mask;
  logic [WIDTH-1:0]  bank_data;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rd_go     = 1'b0;
    bank_we   = '0;
    bank_idx  = w_index;
    bank_mask = w_mask;
    bank_data = data_in;
    unique case (state_q)
      StClear: begin
        // Clear owns the write port: zero every way at clr_idx.
        bank_we   = '1;
        bank_idx  = clr_idx_q;
        bank_mask = '1;
        bank_data = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == Iw'(DEPTH - 1)) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end
      end
      StReady: begin
        rd_go   = rd_en;
        bank_we = wr_en ? w_way : '0;
        if (flush_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StClear;
      clr_idx_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rd_valid_q <= rd_go;
    end
  end

  assign ready    = (state_q == StReady);
  assign rd_valid = rd_valid_q;

  for (genvar k = 0; k < WAYS; k++) begin : g_way
    cache_way_bank #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .SEG_W (SEG_W),
      .FWD   (FWD)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_we[k]),
      .w_index (bank_idx),
      .w_mask  (bank_mask),
      .w_data  (bank_data),
      .rd_en   (rd_go),
      .r_index (r_index),
      .rd_data (rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_cache_set_ram.sv
`timescale 1ns/1ps
module tb_cache_set_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Default geometry, shared stimulus: dut_a has FWD=1, dut_b has FWD=0.
  logic         flush_req, rd_en, wr_en;
  logic [5:0]   r_index, w_index;
  logic [1:0]   w_way;
  logic [3:0]   w_mask;
  logic [127:0] data_in;
  logic         ready_a, rd_valid_a, ready_b, rd_valid_b;
  logic [255:0] rd_data_a, rd_data_b;

  // Small geometry: 4 ways, 16 sets, 64 bits, 8-bit segments.
  logic         flush_c, rd_en_c, wr_en_c;
  logic [3:0]   r_index_c, w_index_c, w_way_c;
  logic [7:0]   w_mask_c;
  logic [63:0]  data_in_c;
  logic         ready_c, rd_valid_c;
  logic [255:0] rd_data_c;

  cache_set_ram #(.FWD(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .flush_req(flush_req), .rd_en(rd_en),
    .r_index(r_index), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en),
    .w_way(w_way), .w_index(w_index), .w_mask(w_mask), .data_in(data_in)
  );

  cache_set_ram #(.FWD(0)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .flush_req(flush_req), .rd_en(rd_en),
    .r_index(r_index), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en),
    .w_way(w_way), .w_index(w_index), .w_mask(w_mask), .data_in(data_in)
  );

  cache_set_ram #(.WAYS(4), .DEPTH(16), .WIDTH(64), .SEG_W(8), .FWD(1)) dut_c (
    .clk(clk), .rst(rst), .ready(ready_c), .flush_req(flush_c), .rd_en(rd_en_c),
    .r_index(r_index_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c), .wr_en(wr_en_c),
    .w_way(w_way_c), .w_index(w_index_c), .w_mask(w_mask_c), .data_in(data_in_c)
  );

  localparam logic [127:0] D28   = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
  localparam logic [127:0] E28   = 128'h0000_0000_CCCC_DDDD_0000_0000_3333_4444;
  localparam logic [127:0] E9W0  = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_1234;
  localparam logic [127:0] D7    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
  localparam logic [63:0]  EC28  = 64'h0022_0044_0066_0088;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_req = 0; rd_en = 0; wr_en = 0; r_index = 0; w_index = 0;
    w_way = 0; w_mask = 0; data_in = 0;
    flush_c = 0; rd_en_c = 0; wr_en_c = 0; r_index_c = 0; w_index_c = 0;
    w_way_c = 0; w_mask_c = 0; data_in_c = 0;
  endtask

  // Counts edges from now until each ready rises (0 if it never does).
  task automatic count_clear(output int na, output int nb, output int nc);
    na = 0; nb = 0; nc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (na == 0 && ready_a) na = i;
      if (nb == 0 && ready_b) nb = i;
      if (nc == 0 && ready_c) nc = i;
      if (na != 0 && nb != 0 && nc != 0) break;
    end
  endtask

  task automatic test_reset();
    int na, nb, nc;
    int idx_ab [3] = '{0, 31, 63};
    int idx_c  [3] = '{0, 7, 15};
    rst = 0;
    idle();
    tick(); tick();
    checks++;
    if ({ready_a, rd_valid_a, ready_b, ready_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {ready_a, rd_valid_a, ready_b, ready_c});
    end
    checks++;
    if (rd_data_a !== '0 || rd_data_c !== '0) begin
      errors++;
      $display("FAIL reset_rd_data: got a=%h c=%h required 0", rd_data_a, rd_data_c);
    end
    rst = 1;
    count_clear(na, nb, nc);
    checks++;
    if (na !== 64 || nb !== 64) begin
      errors++;
      $display("FAIL reset_clear_len: got a=%0d b=%0d required 64", na, nb);
    end
    checks++;
    if (nc !== 16) begin
      errors++;
      $display("FAIL reset_clear_len_c: got %0d required 16", nc);
    end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1; r_index = 6'(idx_ab[i]);
      rd_en_c = 1; r_index_c = 4'(idx_c[i]);
      tick();
      checks++;
      if ({rd_valid_a, rd_data_a} !== {1'b1, 256'h0} || rd_data_b !== '0) begin
        errors++;
        $display("FAIL reset_read_zero: idx %0d got v=%b a=%h b=%h required v=1 data 0",
                 idx_ab[i], rd_valid_a, rd_data_a, rd_data_b);
      end
      checks++;
      if ({rd_valid_c, rd_data_c} !== {1'b1, 256'h0}) begin
        errors++;
        $display("FAIL reset_read_zero_c: idx %0d got v=%b d=%h required v=1 data 0",
                 idx_c[i], rd_valid_c, rd_data_c);
      end
    end
    idle();
  endtask

  task automatic test_masked_write();
    wr_en = 1; w_way = 2'b10; w_index = 5; w_mask = 4'b0101; data_in = D28;
    tick();
    wr_en = 0; rd_en = 1; r_index = 5;
    tick();
    checks++;
    if (rd_data_a !== {E28, 128'h0} || rd_data_b !== {E28, 128'h0}) begin
      errors++;
      $display("FAIL masked_write: got a=%h b=%h required %h", rd_data_a, rd_data_b, {E28, 128'h0});
    end
    // Writes with an empty way mask or empty segment mask change nothing.
    rd_en = 0;
    wr_en = 1; w_way = 2'b00; w_mask = 4'hF; data_in = '1;
    tick();
    w_way = 2'b11; w_mask = 4'h0;
    tick();
    wr_en = 0; rd_en = 1;
    tick();
    checks++;
    if (rd_data_a !== {E28, 128'h0}) begin
      errors++;
      $display("FAIL null_write: got %h required %h", rd_data_a, {E28, 128'h0});
    end
    // No read: rd_data holds, rd_valid drops.
    rd_en = 0; wr_en = 1; w_way = 2'b11; w_index = 6; w_mask = 4'hF; data_in = '1;
    tick();
    wr_en = 0;
    checks++;
    if ({rd_valid_a, rd_data_a} !== {1'b0, E28, 128'h0}) begin
      errors++;
      $display("FAIL read_hold: got v=%b d=%h required v=0 d=%h", rd_valid_a, rd_data_a,
               {E28, 128'h0});
    end
    wr_en_c = 1; w_way_c = 4'b0010; w_index_c = 5; w_mask_c = 8'h55;
    data_in_c = 64'h1122_3344_5566_7788;
    tick();
    wr_en_c = 0; rd_en_c = 1; r_index_c = 5;
    tick();
    checks++;
    if (rd_data_c !== {64'h0, 64'h0, EC28, 64'h0}) begin
      errors++;
      $display("FAIL masked_write_c: got %h required %h", rd_data_c, {64'h0, 64'h0, EC28, 64'h0});
    end
    idle();
  endtask

  task automatic test_forward();
    wr_en = 1; w_way = 2'b11; w_index = 9; w_mask = 4'hF; data_in = 128'h1234;
    rd_en = 1; r_index = 9;
    tick();
    checks++;
    if (rd_data_a !== {2{128'h1234}}) begin
      errors++;
      $display("FAIL fwd_full: got %h required %h", rd_data_a, {2{128'h1234}});
    end
    checks++;
    if (rd_data_b !== '0) begin
      errors++;
      $display("FAIL nofwd_full: got %h required 0", rd_data_b);
    end
    // Partial write into way 0 while reading: merge of old and new segments.
    w_way = 2'b01; w_mask = 4'b0010; data_in = '1;
    tick();
    checks++;
    if (rd_data_a !== {128'h1234, E9W0}) begin
      errors++;
      $display("FAIL fwd_merge: got %h required %h", rd_data_a, {128'h1234, E9W0});
    end
    checks++;
    if (rd_data_b !== {2{128'h1234}}) begin
      errors++;
      $display("FAIL nofwd_merge: got %h required %h", rd_data_b, {2{128'h1234}});
    end
    wr_en = 0;
    tick();
    checks++;
    if (rd_data_b !== {128'h1234, E9W0}) begin
      errors++;
      $display("FAIL after_merge: got %h required %h", rd_data_b, {128'h1234, E9W0});
    end
    wr_en_c = 1; w_way_c = 4'hF; w_index_c = 9; w_mask_c = 8'hFF; data_in_c = 64'h1234;
    rd_en_c = 1; r_index_c = 9;
    tick();
    checks++;
    if (rd_data_c !== {4{64'h1234}}) begin
      errors++;
      $display("FAIL fwd_full_c: got %h required %h", rd_data_c, {4{64'h1234}});
    end
    idle();
  endtask

  task automatic test_back_to_back();
    rd_en = 1; r_index = 5;
    tick();
    r_index = 9;
    checks++;
    if ({rd_valid_a, rd_data_a} !== {1'b1, E28, 128'h0}) begin
      errors++;
      $display("FAIL b2b_idx5: got %h required %h", rd_data_a, {E28, 128'h0});
    end
    tick();
    r_index = 6;
    checks++;
    if ({rd_valid_a, rd_data_a} !== {1'b1, 128'h1234, E9W0}) begin
      errors++;
      $display("FAIL b2b_idx9: got %h required %h", rd_data_a, {128'h1234, E9W0});
    end
    tick();
    checks++;
    if (rd_data_a !== {256{1'b1}}) begin
      errors++;
      $display("FAIL b2b_idx6: got %h required all ones", rd_data_a);
    end
    idle();
  endtask

  task automatic test_flush();
    int n, vbad;
    wr_en = 1; w_way = 2'b11; w_index = 7; w_mask = 4'hF; data_in = D7;
    tick();
    wr_en = 0; flush_req = 1; rd_en = 1; r_index = 7;
    tick();
    checks++;
    if ({rd_valid_a, rd_data_a} !== {1'b1, D7, D7}) begin
      errors++;
      $display("FAIL flush_read_same_cycle: got v=%b d=%h required v=1 d=%h", rd_valid_a,
               rd_data_a, {D7, D7});
    end
    n = 1; vbad = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 2) flush_req = 0;
      tick();
      if (ready_a) break;
      n++;
      if (rd_valid_a) vbad++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL flush_clear_len: got %0d required 64", n);
    end
    checks++;
    if (vbad !== 0 || rd_data_a !== {D7, D7}) begin
      errors++;
      $display("FAIL flush_read_blocked: got valids=%0d d=%h required 0 and %h", vbad,
               rd_data_a, {D7, D7});
    end
    tick();
    checks++;
    if ({rd_valid_a, rd_data_a, rd_data_b} !== {1'b1, 512'h0}) begin
      errors++;
      $display("FAIL flush_idx7_zero: got v=%b a=%h b=%h required v=1 data 0", rd_valid_a,
               rd_data_a, rd_data_b);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int na, nb, nc;
    wr_en = 1; w_way = 2'b01; w_index = 3; w_mask = 4'hF; data_in = 128'hFACE;
    rd_en_c = 1; r_index_c = 5;
    tick();
    wr_en = 0; rd_en_c = 0; flush_req = 1; rd_en = 1; r_index = 3;
    tick();
    flush_req = 0; rd_en = 0;
    repeat (30) tick();
    rst = 0;
    #2;
    checks++;
    if ({ready_a, rd_valid_a, ready_c} !== 3'b000 || rd_data_a !== '0 || rd_data_c !== '0) begin
      errors++;
      $display("FAIL midclear_reset: got r=%b v=%b rc=%b a=%h c=%h required all 0", ready_a,
               rd_valid_a, ready_c, rd_data_a, rd_data_c);
    end
    tick();
    rst = 1;
    count_clear(na, nb, nc);
    checks++;
    if (na !== 64 || nb !== 64 || nc !== 16) begin
      errors++;
      $display("FAIL midclear_len: got a=%0d b=%0d c=%0d required 64 64 16", na, nb, nc);
    end
    rd_en = 1; r_index = 3;
    tick();
    checks++;
    if ({rd_valid_a, rd_data_a} !== {1'b1, 256'h0}) begin
      errors++;
      $display("FAIL midclear_idx3_zero: got v=%b d=%h required v=1 data 0", rd_valid_a,
               rd_data_a);
    end
    idle();
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_masked_write();
    test_forward();
    test_back_to_back();
    test_flush();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
